lc3b_mem_arbiter: RTL and testbench

LC3B_MEM_ARBITER -- requirements
Module: lc3b_mem_arbiter

---
 rtl/lc3b_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a single-port memory with a fixed wait-state count.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate ties between requesters instead of always favouring the CPU.
module lc3b_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [1:0]  dma_be,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        cpu_done,
  output logic        dma_done,
  output logic        cpu_gnt,
  output logic        dma_gnt,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        tie_to_cpu;
  logic        cpu_wins;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_to_cpu = (owner_q == OWN_DMA);
`else
    tie_to_cpu = 1'b1;
`endif
    cpu_wins = cpu_req && (!dma_req || tie_to_cpu);

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = cpu_wins ? OWN_CPU : OWN_DMA;
          we_d    = cpu_wins ? cpu_we    : dma_we;
          be_d    = cpu_wins ? cpu_be    : dma_be;
          addr_d  = cpu_wins ? cpu_addr  : dma_addr;
          wdata_d = cpu_wins ? cpu_wdata : dma_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Memory data is taken on the last wait edge; for writes it is a harmless don't-care.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every flop, including the held memory bus.
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_DMA;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_en    = (state_q == S_BUSY);
  assign mem_we    = mem_en && we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign cpu_gnt   = (state_q != S_IDLE) && (owner_q == OWN_CPU);
  assign dma_gnt   = (state_q != S_IDLE) && (owner_q == OWN_DMA);
  assign cpu_done  = (state_q == S_RESP) && (owner_q == OWN_CPU);
  assign dma_done  = (state_q == S_RESP) && (owner_q == OWN_DMA);

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Bench for lc3b_mem_arbiter: directed scenarios on WAIT_CYCLES=2 and 0 instances, then randomized
// traffic on the WAIT_CYCLES=2 instance against a transaction-level timing/memory model.
module tb_lc3b_mem_arbiter;

  localparam int W = 2;

  logic clk, rst_n;
  logic cpu_req, cpu_we, dma_req, dma_we;
  logic [1:0] cpu_be, dma_be;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic a_cpu_done, a_dma_done, a_cpu_gnt, a_dma_gnt, a_mem_en, a_mem_we;
  logic [1:0] a_mem_be;
  logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic z_cpu_done, z_dma_done, z_cpu_gnt, z_dma_gnt, z_mem_en, z_mem_we;
  logic [1:0] z_mem_be;
  logic [15:0] z_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  bit [15:0] mem_a [256];
  bit        val_a [256];
  bit [15:0] mem_z [256];
  bit        val_z [256];
  bit [15:0] ref_mem [256];
  bit        ref_val [256];

  function automatic logic [15:0] init_word(input logic [7:0] idx);
    return (idx == 8'd0) ? 16'hBEEF : {idx, idx ^ 8'h5A};
  endfunction

  function automatic logic [15:0] merge_be(input logic [15:0] old_w, input logic [15:0] new_w,
                                           input logic [1:0] be);
    return {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
  endfunction

  lc3b_mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_done(a_cpu_done), .dma_done(a_dma_done), .cpu_gnt(a_cpu_gnt), .dma_gnt(a_dma_gnt),
    .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  lc3b_mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_done(z_cpu_done), .dma_done(z_dma_done), .cpu_gnt(z_cpu_gnt), .dma_gnt(z_dma_gnt),
    .rdata(z_rdata), .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_be(z_mem_be),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple word memories behind each instance; unwritten words read a fixed address pattern.
  assign a_mem_rdata = val_a[a_mem_addr[8:1]] ? mem_a[a_mem_addr[8:1]] : init_word(a_mem_addr[8:1]);
  assign z_mem_rdata = val_z[z_mem_addr[8:1]] ? mem_z[z_mem_addr[8:1]] : init_word(z_mem_addr[8:1]);

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr[8:1]] <= merge_be(a_mem_rdata, a_mem_wdata, a_mem_be);
      val_a[a_mem_addr[8:1]] <= 1'b1;
    end
    if (z_mem_en && z_mem_we) begin
      mem_z[z_mem_addr[8:1]] <= merge_be(z_mem_rdata, z_mem_wdata, z_mem_be);
      val_z[z_mem_addr[8:1]] <= 1'b1;
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_be = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [55:0] got_a, got_z;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    got_a = {a_cpu_done, a_dma_done, a_cpu_gnt, a_dma_gnt, a_mem_en, a_mem_we, a_mem_be,
             a_mem_addr, a_mem_wdata, a_rdata};
    got_z = {z_cpu_done, z_dma_done, z_cpu_gnt, z_dma_gnt, z_mem_en, z_mem_we, z_mem_be,
             z_mem_addr, z_mem_wdata, z_rdata};
    n_cmp++;
    if (got_a !== 56'd0) begin n_bad++; $display("FAIL reset_outputs_w2: got %h expected 0", got_a); end
    n_cmp++;
    if (got_z !== 56'd0) begin n_bad++; $display("FAIL reset_outputs_w0: got %h expected 0", got_z); end
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    int en_cnt = 0, done_cnt = 0, done_at = -1;
    logic addr_ok = 1'b1;
    logic [15:0] rd = 16'hxxxx;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (a_mem_en) begin
        en_cnt++;
        if (a_mem_addr !== 16'h3000 || a_mem_we !== 1'b0 || a_cpu_gnt !== 1'b1) addr_ok = 1'b0;
      end
      if (a_cpu_done) begin
        done_cnt++; done_at = i; rd = a_rdata; cpu_req = 0;
      end
    end
    n_cmp++;
    if (en_cnt != W + 1) begin n_bad++; $display("FAIL read_en_cycles: got %0d expected %0d", en_cnt, W + 1); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL read_done_pulses: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (done_at != W + 1) begin n_bad++; $display("FAIL read_done_latency: got %0d expected %0d", done_at, W + 1); end
    n_cmp++;
    if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL read_rdata: got %h expected beef", rd); end
    n_cmp++;
    if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL read_bus_stable: got %b expected 1", addr_ok); end
    n_cmp++;
    if (a_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL read_rdata_hold: got %h expected beef", a_rdata); end
  endtask

  task automatic test_dma_write_w0();
    int en_cnt = 0, done_at = -1;
    logic bus_ok = 1'b1, cpu_seen = 1'b0;
    do_reset();
    dma_req = 1; dma_we = 1; dma_be = 2'b11; dma_addr = 16'h4002; dma_wdata = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (z_cpu_gnt) cpu_seen = 1'b1;
      if (z_mem_en) begin
        en_cnt++;
        if (z_mem_we !== 1'b1 || z_mem_addr !== 16'h4002 || z_mem_wdata !== 16'h1234 ||
            z_mem_be !== 2'b11 || z_dma_gnt !== 1'b1) bus_ok = 1'b0;
      end
      if (z_dma_done) begin done_at = i; dma_req = 0; end
    end
    n_cmp++;
    if (en_cnt != 1) begin n_bad++; $display("FAIL w0_en_cycles: got %0d expected 1", en_cnt); end
    n_cmp++;
    if (bus_ok !== 1'b1) begin n_bad++; $display("FAIL w0_write_bus: got %b expected 1", bus_ok); end
    n_cmp++;
    if (done_at != 1) begin n_bad++; $display("FAIL w0_done_latency: got %0d expected 1", done_at); end
    n_cmp++;
    if (cpu_seen !== 1'b0) begin n_bad++; $display("FAIL w0_cpu_gnt: got %b expected 0", cpu_seen); end
    n_cmp++;
    if (mem_z[1] !== 16'h1234) begin n_bad++; $display("FAIL w0_mem_written: got %h expected 1234", mem_z[1]); end
  endtask

  task automatic test_tie();
    logic [3:0] seq = 4'd0;
    logic [3:0] exp_seq;
    logic dma_seen = 1'b0, exp_dma_seen;
    int n = 0;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 16'h0000; cpu_wdata = 16'h0;
    dma_req = 1; dma_we = 0; dma_be = 2'b11; dma_addr = 16'h0002; dma_wdata = 16'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010; exp_dma_seen = 1'b1;
`else
    exp_seq = 4'b0000; exp_dma_seen = 1'b0;
`endif
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (a_dma_gnt) dma_seen = 1'b1;
      if (a_cpu_done || a_dma_done) begin
        seq[n] = a_dma_done;
        n++;
      end
    end
    n_cmp++;
    if (n != 4) begin n_bad++; $display("FAIL tie_access_count: got %0d expected 4", n); end
    n_cmp++;
    if (seq !== exp_seq) begin n_bad++; $display("FAIL tie_grant_order: got %b expected %b", seq, exp_seq); end
    n_cmp++;
    if (dma_seen !== exp_dma_seen) begin n_bad++; $display("FAIL tie_dma_granted: got %b expected %b", dma_seen, exp_dma_seen); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [55:0] got;
    int done_cnt = 0, done_at = -1;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (a_mem_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy2: got %b expected 1", a_mem_en); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    got = {a_cpu_done, a_dma_done, a_cpu_gnt, a_dma_gnt, a_mem_en, a_mem_we, a_mem_be,
           a_mem_addr, a_mem_wdata, a_rdata};
    n_cmp++;
    if (got !== 56'd0) begin n_bad++; $display("FAIL rstmid_outputs: got %h expected 0", got); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (a_cpu_done) begin done_cnt++; done_at = i; cpu_req = 0; end
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != W + 1)
      begin n_bad++; $display("FAIL rstmid_restart: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_at, W + 1); end
    n_cmp++;
    if (a_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rstmid_rdata: got %h expected beef", a_rdata); end
  endtask

  task automatic test_drop_write();
    int done_cnt = 0, done_at = -1;
    logic [15:0] wd;
    logic [3:0] tail;
    wd = 16'($urandom);
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_be = 2'b11; cpu_addr = 16'h0010; cpu_wdata = wd;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) cpu_req = 0;
      if (a_cpu_done) begin done_cnt++; done_at = i; end
    end
    tail = {a_mem_en, a_mem_we, a_cpu_gnt, a_dma_gnt};
    n_cmp++;
    if (done_cnt != 1 || done_at != W + 1)
      begin n_bad++; $display("FAIL drop_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_at, W + 1); end
    n_cmp++;
    if (mem_a[8] !== wd) begin n_bad++; $display("FAIL drop_mem_written: got %h expected %h", mem_a[8], wd); end
    n_cmp++;
    if (tail !== 4'd0) begin n_bad++; $display("FAIL drop_idle_after: got %b expected 0000", tail); end
  endtask

  task automatic test_random();
    int cur = 0, s = 0, next_ok = 1;
    bit have = 0, own_dma = 0, last_dma = 1, infl_c = 0, infl_d = 0;
    bit busy, done, tie_dma, win_dma;
    logic t_we;
    logic [1:0] t_be;
    logic [15:0] t_addr, t_wdata, exp_rd;
    logic [5:0] exp_ctl, got_ctl;
    logic [33:0] exp_bus, got_bus;
    logic [7:0] idx;
    t_we = 0; t_be = 0; t_addr = 0; t_wdata = 0;
    for (int i = 0; i < 256; i++) ref_val[i] = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      busy = have && cur >= s && cur <= s + W;
      done = have && cur == s + W + 1;
      exp_ctl = {busy, busy && t_we, (busy || done) && !own_dma, (busy || done) && own_dma,
                 done && !own_dma, done && own_dma};
      got_ctl = {a_mem_en, a_mem_we, a_cpu_gnt, a_dma_gnt, a_cpu_done, a_dma_done};
      n_cmp++;
      if (got_ctl !== exp_ctl)
        begin n_bad++; $display("FAIL rand_ctl cyc %0d: got %b expected %b", cur, got_ctl, exp_ctl); end
      exp_bus = have ? {t_be, t_addr, t_wdata} : 34'd0;
      got_bus = {a_mem_be, a_mem_addr, a_mem_wdata};
      n_cmp++;
      if (got_bus !== exp_bus)
        begin n_bad++; $display("FAIL rand_bus cyc %0d: got %h expected %h", cur, got_bus, exp_bus); end
      if (done) begin
        idx = t_addr[8:1];
        if (!t_we) begin
          exp_rd = ref_val[idx] ? ref_mem[idx] : init_word(idx);
          n_cmp++;
          if (a_rdata !== exp_rd)
            begin n_bad++; $display("FAIL rand_rdata cyc %0d: got %h expected %h", cur, a_rdata, exp_rd); end
        end else begin
          ref_mem[idx] = merge_be(ref_val[idx] ? ref_mem[idx] : init_word(idx), t_wdata, t_be);
          ref_val[idx] = 1;
        end
        if (own_dma) begin dma_req = 0; infl_d = 0; end
        else         begin cpu_req = 0; infl_c = 0; end
      end
      // Owners may drop req mid-access; idle requesters start new accesses at random.
      if (infl_c && cpu_req && $urandom_range(7) == 0) cpu_req = 0;
      if (infl_d && dma_req && $urandom_range(7) == 0) dma_req = 0;
      if (!cpu_req && !infl_c && $urandom_range(2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_be = 2'($urandom); cpu_wdata = 16'($urandom);
        cpu_addr = {7'($urandom), 8'($urandom_range(255, 16)), 1'($urandom)};
      end
      if (!dma_req && !infl_d && $urandom_range(2) == 0) begin
        dma_req = 1; dma_we = 1'($urandom); dma_be = 2'($urandom); dma_wdata = 16'($urandom);
        dma_addr = {7'($urandom), 8'($urandom_range(255, 16)), 1'($urandom)};
      end
      if (cur + 1 >= next_ok && (cpu_req || dma_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_dma = !last_dma;
`else
        tie_dma = 0;
`endif
        win_dma = dma_req && (!cpu_req || tie_dma);
        t_we    = win_dma ? dma_we    : cpu_we;
        t_be    = win_dma ? dma_be    : cpu_be;
        t_addr  = win_dma ? dma_addr  : cpu_addr;
        t_wdata = win_dma ? dma_wdata : cpu_wdata;
        have = 1; s = cur + 1; own_dma = win_dma; last_dma = win_dma; next_ok = s + W + 3;
        if (win_dma) infl_d = 1; else infl_c = 1;
      end
      @(posedge clk); @(negedge clk);
      cur++;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_dma_write_w0();
    test_tie();
    test_reset_mid();
    test_drop_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
